// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO; frames go out back-to-back while data is queued.
// Latency: a word pushed into an empty FIFO while idle pops on the next edge and the start bit begins there.
// Backpressure: o_ready drops only when the FIFO is full; a same-cycle pop does not re-open it.
module uart_tx_fifo #(
  parameter int clk_freq_hz = 48000000,
  parameter int baud_rate   = 57600,
  parameter int data_bits   = 8,
  parameter int parity      = 0,
  parameter int stop_bits   = 1,
  parameter int fifo_depth  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [data_bits-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_uart_tx,
  output logic                          o_busy,
  output logic [$clog2(fifo_depth):0]   o_level
);

  localparam int DIV = clk_freq_hz / baud_rate;
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(fifo_depth);

  localparam logic [CW-1:0] BAUD_LAST  = CW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST  = 4'(data_bits - 1);
  localparam logic [3:0]    STOP_LAST  = 4'(stop_bits - 1);
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(fifo_depth);

  // Reject parameter sets the datapath cannot represent.
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: clk_freq_hz/baud_rate must be at least 2");
  end
  if (data_bits < 5 || data_bits > 9) begin : g_bad_bits
    $error("uart_tx_fifo: data_bits must be 5..9");
  end
  if (parity < 0 || parity > 2) begin : g_bad_par
    $error("uart_tx_fifo: parity must be 0, 1 or 2");
  end
  if (stop_bits < 1 || stop_bits > 2) begin : g_bad_stop
    $error("uart_tx_fifo: stop_bits must be 1 or 2");
  end
  if (fifo_depth < 2 || (1 << AW) != fifo_depth) begin : g_bad_depth
    $error("uart_tx_fifo: fifo_depth must be a power of two >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [data_bits-1:0] r_mem [fifo_depth];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_level;

  state_t               r_state;
  logic [CW-1:0]        r_baud_cnt;
  logic [3:0]           r_bit_cnt;
  logic [data_bits-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_nonempty;
  logic                 w_baud_done;
  logic                 w_last_stop;
  logic [data_bits-1:0] w_head;

  assign w_nonempty  = (r_level != '0);
  assign w_baud_done = (r_baud_cnt == BAUD_LAST);
  assign w_last_stop = (r_state == S_STOP) && w_baud_done && (r_bit_cnt == STOP_LAST);
  // The head leaves the FIFO only when the shifter is free: idle, or the last stop bit is ending.
  assign w_pop       = w_nonempty && ((r_state == S_IDLE) || w_last_stop);
  assign w_push      = i_valid && o_ready;
  assign w_head      = r_mem[r_rd_ptr];

  assign o_ready   = (r_level != LEVEL_FULL);
  assign o_level   = r_level;
  assign o_busy    = (r_state != S_IDLE) || w_nonempty;
  assign o_uart_tx = r_tx;

  // FIFO storage; stray writes during reset are harmless because the pointers are held.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Frame sequencer: each bit holds for DIV clocks, line value registered with the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_baud_cnt <= w_baud_done ? '0 : r_baud_cnt + 1'b1;
      if (w_pop) begin
        r_shift    <= w_head;
        r_par      <= (parity == 1) ? ~^w_head : ^w_head;
        r_state    <= S_START;
        r_bit_cnt  <= '0;
        r_baud_cnt <= '0;
        r_tx       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
          end
          S_START: if (w_baud_done) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
            r_tx      <= r_shift[0];
          end
          S_DATA: if (w_baud_done) begin
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= '0;
              if (parity != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end
          S_PARITY: if (w_baud_done) begin
            r_state   <= S_STOP;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
          end
          S_STOP: if (w_baud_done) begin
            if (r_bit_cnt == STOP_LAST) begin
              r_state   <= S_IDLE;
              r_bit_cnt <= '0;
              r_tx      <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
